// File: rtl/hvsync_gen.sv
// hvsync_gen: raster timing generator for the 256x240 Mango One display
//   clk        pixel clock, all state updates on the rising edge
//   reset      asynchronous active-low reset
//   hpos       horizontal counter 0..H_MAX
//   vpos       vertical counter 0..V_MAX
//   hsync      registered horizontal sync, one clock behind hpos
//   vsync      registered vertical sync, one clock behind vpos
//   display_on combinational visible-area flag, no lag
module hvsync_gen #(
  parameter int H_DISPLAY        = 256,
  parameter int H_BACK           = 23,
  parameter int H_FRONT          = 7,
  parameter int H_SYNC           = 23,
  parameter int V_DISPLAY        = 240,
  parameter int V_TOP            = 5,
  parameter int V_BOTTOM         = 14,
  parameter int V_SYNC           = 3,
  parameter int SYNC_ACTIVE_HIGH = 1
) (
  input  logic       clk,
  input  logic       reset,
  output logic [8:0] hpos,
  output logic [8:0] vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on
);
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int H_MAX        = H_DISPLAY + H_BACK + H_FRONT + H_SYNC - 1;
  localparam int V_SYNC_START = V_DISPLAY + V_BOTTOM;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;
  localparam int V_MAX        = V_DISPLAY + V_TOP + V_BOTTOM + V_SYNC - 1;
  localparam logic ACT        = SYNC_ACTIVE_HIGH != 0;
  if (H_SYNC == 0 || V_SYNC == 0 || H_MAX > 511 || V_MAX > 511) begin : g_bad_params
    $error("hvsync_gen: sync widths must be nonzero and H_MAX/V_MAX must fit in 9 bits");
  end
  logic line_end;
  logic h_in_sync;
  logic v_in_sync;
  assign line_end   = hpos == 9'(H_MAX);
  assign h_in_sync  = hpos >= 9'(H_SYNC_START) && hpos <= 9'(H_SYNC_END);
  assign v_in_sync  = vpos >= 9'(V_SYNC_START) && vpos <= 9'(V_SYNC_END);
  assign display_on = hpos < 9'(H_DISPLAY) && vpos < 9'(V_DISPLAY);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      hpos  <= '0;
      vpos  <= '0;
      hsync <= ~ACT;
      vsync <= ~ACT;
    end else begin
      hpos  <= line_end ? '0 : hpos + 9'd1;
      if (line_end) vpos <= vpos == 9'(V_MAX) ? '0 : vpos + 9'd1;
      hsync <= h_in_sync ? ACT : ~ACT;
      vsync <= v_in_sync ? ACT : ~ACT;
    end
endmodule

// File: tb/tb_hvsync_gen.sv
// tb_hvsync_gen: random-reset bench for hvsync_gen against an arithmetic raster model
module tb_hvsync_gen;
  localparam int HT = 309;
  localparam int VT = 262;
  localparam int FRAME = HT * VT;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [8:0] hpos_p, vpos_p, hpos_n, vpos_n;
  logic hsync_p, vsync_p, hsync_n, vsync_n, don_p, don_n;
  int total = 0;
  int bad = 0;
  int t = 0;
  int hs_cnt = 0;
  int vs_cnt = 0;
  hvsync_gen dut_p (.clk(clk), .reset(reset), .hpos(hpos_p), .vpos(vpos_p),
                    .hsync(hsync_p), .vsync(vsync_p), .display_on(don_p));
  hvsync_gen #(.SYNC_ACTIVE_HIGH(0)) dut_n (.clk(clk), .reset(reset), .hpos(hpos_n), .vpos(vpos_n),
                    .hsync(hsync_n), .vsync(vsync_n), .display_on(don_n));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%0d exp=%0d", tag, t, got, exp);
    end
  endtask
  task automatic check_reset_state();
    chk("rst_hpos", hpos_p, 0);
    chk("rst_vpos", vpos_p, 0);
    chk("rst_hsync", hsync_p, 0);
    chk("rst_vsync", vsync_p, 0);
    chk("rst_don", don_p, 1);
    chk("rst_hsync_n", hsync_n, 1);
    chk("rst_vsync_n", vsync_n, 1);
    chk("rst_hpos_n", hpos_n, 0);
  endtask
  task automatic check_model();
    int h, v, ph, pv, hs, vs, d;
    h  = t % HT;
    v  = (t / HT) % VT;
    ph = (t - 1) % HT;
    pv = ((t - 1) / HT) % VT;
    hs = (t > 0 && ph >= 263 && ph <= 285) ? 1 : 0;
    vs = (t > 0 && pv >= 254 && pv <= 256) ? 1 : 0;
    d  = (h < 256 && v < 240) ? 1 : 0;
    chk("hpos", hpos_p, h);
    chk("vpos", vpos_p, v);
    chk("hsync", hsync_p, hs);
    chk("vsync", vsync_p, vs);
    chk("display_on", don_p, d);
    chk("hpos_n", hpos_n, h);
    chk("vpos_n", vpos_n, v);
    chk("hsync_n", hsync_n, 1 - hs);
    chk("vsync_n", vsync_n, 1 - vs);
    chk("display_on_n", don_n, d);
  endtask
  task automatic step();
    @(posedge clk);
    t++;
    @(negedge clk);
    check_model();
    if (t < HT && hsync_p) hs_cnt++;
    if (t <= FRAME && vsync_p) vs_cnt++;
  endtask
  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    t = 0;
    #1 check_model();
  endtask
  task automatic async_reset(input int hold);
    #2 reset = 1'b0;
    #1 check_reset_state();
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_reset_state();
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check_reset_state();
    release_reset();
    repeat (5) step();
    chk("five_edges_hpos", hpos_p, 5);
    for (int i = 5; i < FRAME + 3; i++) step();
    chk("hsync_width", hs_cnt, 23);
    chk("vsync_cycles", vs_cnt, 3 * HT);
    for (int k = 0; k < 6; k++) begin
      async_reset($urandom_range(1, 3));
      release_reset();
      for (int i = $urandom_range(1, 2500); i > 0; i--) step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
